axi4lite_slave_regs: RTL and testbench

//  AXI4-Lite slave register bank that terminates the master driver's five channels.

---
 rtl/axi4lite_slave_regs.sv | 172 +++++++++++++++++
 tb/tb_axi4lite_slave_regs.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_slave_regs.sv
// AXI4-Lite slave holding NUM_REGS 32-bit byte-strobed registers.
// Write and read channels run as independent two-state machines.
module axi4lite_slave_regs #(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              AWVALID,
    output logic              AWREADY,
    input  logic [ADDR_W-1:0] AWADDR,
    input  logic [2:0]        AWPROT,
    input  logic              WVALID,
    output logic              WREADY,
    input  logic [DATA_W-1:0] WDATA,
    input  logic [3:0]        WSTRB,
    output logic              BVALID,
    input  logic              BREADY,
    output logic [1:0]        BRESP,
    input  logic              ARVALID,
    output logic              ARREADY,
    input  logic [ADDR_W-1:0] ARADDR,
    input  logic [2:0]        ARPROT,
    output logic              RVALID,
    input  logic              RREADY,
    output logic [DATA_W-1:0] RDATA,
    output logic [1:0]        RRESP
);
    localparam int IDX_W = $clog2(NUM_REGS);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    wstate_t wstate, wstate_nxt;
    rstate_t rstate, rstate_nxt;

    logic                             rdy_en;
    logic                             aw_held, w_held;
    logic [IDX_W-1:0]                 aw_idx_q;
    logic                             aw_oor_q;
    logic [DATA_W-1:0]                wdata_q;
    logic [3:0]                       wstrb_q;
    logic [NUM_REGS-1:0][DATA_W-1:0]  regs;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, commit;
    logic [IDX_W-1:0]  wr_idx, rd_idx;
    logic              wr_oor, rd_oor;
    logic [DATA_W-1:0] wr_data;
    logic [3:0]        wr_strb;

    logic unused_bits;
    assign unused_bits = ^{AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0]};

    function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
        return (a >> (IDX_W + 2)) != '0;
    endfunction

    assign aw_hs = AWVALID && AWREADY;
    assign w_hs  = WVALID && WREADY;
    assign b_hs  = BVALID && BREADY;
    assign ar_hs = ARVALID && ARREADY;
    assign r_hs  = RVALID && RREADY;

    // Either half may come from its holding register or straight off the bus this cycle.
    assign wr_idx  = aw_held ? aw_idx_q : AWADDR[IDX_W+1:2];
    assign wr_oor  = aw_held ? aw_oor_q : out_of_range(AWADDR);
    assign wr_data = w_held  ? wdata_q  : WDATA;
    assign wr_strb = w_held  ? wstrb_q  : WSTRB;
    assign commit  = (wstate == W_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);

    assign rd_idx = ARADDR[IDX_W+1:2];
    assign rd_oor = out_of_range(ARADDR);

    // Keeps all readies low until the first edge after reset release.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) rdy_en <= 1'b0;
        else          rdy_en <= 1'b1;
    end

    // ---------------- write path ----------------
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) wstate <= W_IDLE;
        else          wstate <= wstate_nxt;
    end

    always_comb begin
        wstate_nxt = wstate;
        case (wstate)
            W_IDLE:  if (commit) wstate_nxt = W_RESP;
            W_RESP:  if (BREADY) wstate_nxt = W_IDLE;
            default: wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        BVALID  = (wstate == W_RESP);
        AWREADY = rdy_en && !aw_held && !BVALID;
        WREADY  = rdy_en && !w_held  && !BVALID;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_idx_q <= '0;
            aw_oor_q <= 1'b0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            BRESP    <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                aw_held  <= 1'b1;
                aw_idx_q <= AWADDR[IDX_W+1:2];
                aw_oor_q <= out_of_range(AWADDR);
            end else if (b_hs) begin
                aw_held  <= 1'b0;
            end
            if (w_hs) begin
                w_held  <= 1'b1;
                wdata_q <= WDATA;
                wstrb_q <= WSTRB;
            end else if (b_hs) begin
                w_held  <= 1'b0;
            end
            if (commit) BRESP <= wr_oor ? RESP_SLVERR : RESP_OKAY;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            regs <= '0;
        end else if (commit && !wr_oor) begin
            for (int b = 0; b < 4; b++)
                if (wr_strb[b]) regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
    end

    // ---------------- read path ----------------
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) rstate <= R_IDLE;
        else          rstate <= rstate_nxt;
    end

    always_comb begin
        rstate_nxt = rstate;
        case (rstate)
            R_IDLE:  if (ar_hs) rstate_nxt = R_DATA;
            R_DATA:  if (r_hs)  rstate_nxt = R_IDLE;
            default: rstate_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        RVALID  = (rstate == R_DATA);
        ARREADY = rdy_en && !RVALID;
    end

    // Sampled before this edge's register update, so a same-edge write yields the old value.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            RDATA <= '0;
            RRESP <= RESP_OKAY;
        end else if (ar_hs) begin
            RDATA <= rd_oor ? '0 : regs[rd_idx];
            RRESP <= rd_oor ? RESP_SLVERR : RESP_OKAY;
        end
    end

endmodule

// File: tb/tb_axi4lite_slave_regs.sv
// Directed plus randomized bench for axi4lite_slave_regs against an array-based
// register model.
module tb_axi4lite_slave_regs;
    localparam int NUM_REGS = 8;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        AWVALID = 1'b0, WVALID = 1'b0, BREADY = 1'b0, ARVALID = 1'b0, RREADY = 1'b0;
    logic        AWREADY, WREADY, BVALID, ARREADY, RVALID;
    logic [31:0] AWADDR = '0, ARADDR = '0, WDATA = '0, RDATA;
    logic [3:0]  WSTRB = '0;
    logic [2:0]  AWPROT = '0, ARPROT = '0;
    logic [1:0]  BRESP, RRESP;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] model [NUM_REGS];

    axi4lite_slave_regs #(.NUM_REGS(NUM_REGS), .ADDR_W(32), .DATA_W(32)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: byte-merge into a plain array; anything at or above NUM_REGS*4 errors.
    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                               output logic [1:0] resp);
        if (a >= NUM_REGS * 4) begin
            resp = 2'b10;
        end else begin
            resp = 2'b00;
            for (int i = 0; i < 4; i++)
                if (s[i]) model[int'(a >> 2)][8*i +: 8] = d[8*i +: 8];
        end
    endtask

    task automatic model_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        if (a >= NUM_REGS * 4) begin
            d = 32'h0;
            resp = 2'b10;
        end else begin
            d = model[int'(a >> 2)];
            resp = 2'b00;
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly, input bit hold_b, input bit chk_wready);
        bit aw_done = 0, w_done = 0, aw_now, w_now;
        int cyc = 0;
        logic [1:0] exp_resp;
        model_write(a, d, s, exp_resp);
        while (!(aw_done && w_done) && cyc < 40) begin
            @(negedge ACLK);
            AWVALID = !aw_done && (cyc >= aw_dly);
            AWADDR  = a;
            WVALID  = !w_done && (cyc >= w_dly);
            WDATA   = d;
            WSTRB   = s;
            #1;
            if (chk_wready && w_done && !aw_done) check("wready_low_after_w", WREADY, 0);
            aw_now = AWVALID && AWREADY;
            w_now  = WVALID && WREADY;
            @(posedge ACLK);
            aw_done |= aw_now;
            w_done  |= w_now;
            cyc++;
        end
        check("write_hs_done", aw_done && w_done, 1);
        #1;
        check("bvalid_latency", BVALID, 1);
        check("bresp", BRESP, exp_resp);
        @(negedge ACLK);
        AWVALID = 0;
        WVALID  = 0;
        if (!hold_b) begin
            BREADY = 1;
            @(posedge ACLK);
            #1;
            check("bvalid_cleared", BVALID, 0);
            @(negedge ACLK);
            BREADY = 0;
        end
    endtask

    task automatic do_read(input logic [31:0] a, input bit hold_r);
        int n = 0;
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
        model_read(a, exp_d, exp_r);
        @(negedge ACLK);
        ARVALID = 1;
        ARADDR  = a;
        #1;
        while (!ARREADY && n < 40) begin
            @(negedge ACLK);
            #1;
            n++;
        end
        check("arready_seen", ARREADY, 1);
        @(posedge ACLK);
        #1;
        check("rvalid", RVALID, 1);
        check("rdata", RDATA, exp_d);
        check("rresp", RRESP, exp_r);
        @(negedge ACLK);
        ARVALID = 0;
        if (!hold_r) begin
            RREADY = 1;
            @(posedge ACLK);
            #1;
            check("rvalid_cleared", RVALID, 0);
            @(negedge ACLK);
            RREADY = 0;
        end
    endtask

    initial begin
        logic [31:0] bsnap;
        logic [1:0]  rsnap, dummy;
        for (int i = 0; i < NUM_REGS; i++) model[i] = 32'h0;

        // reset state
        #12;
        check("rst_awready", AWREADY, 0);
        check("rst_wready", WREADY, 0);
        check("rst_arready", ARREADY, 0);
        check("rst_bvalid", BVALID, 0);
        check("rst_rvalid", RVALID, 0);
        check("rst_rdata", RDATA, 0);
        check("rst_resp", {BRESP, RRESP}, 0);
        @(negedge ACLK);
        ARESETN = 1;
        @(posedge ACLK);
        #1;
        check("ready_after_release", {AWREADY, WREADY, ARREADY}, 3'b111);

        // 1: AW and W together
        do_write(32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0);
        do_read(32'h04, 0);

        // 2: W three cycles ahead of AW, single byte strobe
        do_write(32'h04, 32'h000000AA, 4'h1, 3, 0, 0, 1);
        do_read(32'h04, 0);

        // 3: out-of-range write and read
        do_write(32'h20, 32'hCAFEF00D, 4'hF, 0, 0, 0, 0);
        for (int i = 0; i < NUM_REGS; i++) do_read(32'(i * 4), 0);
        do_read(32'h20, 0);

        // 4: B back-pressure with a concurrent read
        do_write(32'h0C, 32'h5A5A1234, 4'hF, 0, 0, 1, 0);
        bsnap = {31'b0, BVALID};
        rsnap = BRESP;
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            AWVALID = 1;
            WVALID  = 1;
            AWADDR  = 32'h10;
            #1;
            check("bp_bvalid", BVALID, bsnap);
            check("bp_bresp", BRESP, rsnap);
            check("bp_aw_w_ready", {AWREADY, WREADY}, 2'b00);
        end
        @(negedge ACLK);
        AWVALID = 0;
        WVALID  = 0;
        do_read(32'h00, 0);
        check("bp_bvalid_after_read", BVALID, 1);
        @(negedge ACLK);
        BREADY = 1;
        @(negedge ACLK);
        BREADY = 0;
        do_read(32'h0C, 0);

        // 5: reset mid-response on both channels
        do_write(32'h18, 32'h11112222, 4'hF, 0, 0, 1, 0);
        do_read(32'h18, 1);
        @(negedge ACLK);
        #2;
        ARESETN = 0;
        #1;
        check("rst_mid_bvalid", BVALID, 0);
        check("rst_mid_rvalid", RVALID, 0);
        check("rst_mid_ready", {AWREADY, WREADY, ARREADY}, 3'b000);
        for (int i = 0; i < NUM_REGS; i++) model[i] = 32'h0;
        @(negedge ACLK);
        ARESETN = 1;
        #1;
        check("ready_before_edge", {AWREADY, WREADY, ARREADY}, 3'b000);
        @(posedge ACLK);
        #1;
        check("ready_first_edge", {AWREADY, WREADY, ARREADY}, 3'b111);
        for (int i = 0; i < NUM_REGS; i++) do_read(32'(i * 4), 0);

        // 6: read and write commit to the same register on one edge
        @(negedge ACLK);
        AWVALID = 1; AWADDR = 32'h08;
        WVALID  = 1; WDATA  = 32'h12345678; WSTRB = 4'hF;
        ARVALID = 1; ARADDR = 32'h08;
        #1;
        check("same_edge_ready", {AWREADY, WREADY, ARREADY}, 3'b111);
        @(posedge ACLK);
        #1;
        check("same_edge_rvalid", RVALID, 1);
        check("same_edge_old_data", RDATA, model[2]);
        check("same_edge_bvalid", BVALID, 1);
        model_write(32'h08, 32'h12345678, 4'hF, dummy);
        @(negedge ACLK);
        AWVALID = 0; WVALID = 0; ARVALID = 0;
        BREADY = 1; RREADY = 1;
        @(negedge ACLK);
        BREADY = 0; RREADY = 0;
        do_read(32'h08, 0);

        // randomized mix
        for (int k = 0; k < 60; k++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, NUM_REGS * 4 + 7));
            if ($urandom_range(0, 1) == 1)
                do_write(a, $urandom, 4'($urandom_range(0, 15)),
                         int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0, 0);
            else
                do_read(a, 0);
        end
        for (int i = 0; i < NUM_REGS; i++) do_read(32'(i * 4), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
